// File: rtl/extender_part_collector_if.sv
// Stream bundle between the Extender output and the part collector.
// Carries the part input handshake and the fragment output handshake.
// master: the surrounding environment (part source + fragment sink).
// slave:  the collector itself.
interface extender_part_collector_if #(
  parameter int unsigned BASE_LEN    = 2,
  parameter int unsigned ONE_HOT_LEN = 4,
  parameter int unsigned PART_COUNT  = 2,
  parameter int unsigned FRAG_LEN    = 256,
  parameter int unsigned LEN_W       = $clog2(FRAG_LEN + 1)
);
  logic                              in_valid;
  logic                              in_ready;
  logic [PART_COUNT*ONE_HOT_LEN-1:0] in_part;
  logic                              in_last;
  logic                              out_valid;
  logic                              out_ready;
  logic [BASE_LEN*FRAG_LEN-1:0]      out_frag;
  logic [LEN_W-1:0]                  out_len;
  logic                              out_err;

  modport master (
    output in_valid, in_part, in_last, out_ready,
    input  in_ready, out_valid, out_frag, out_len, out_err
  );

  modport slave (
    input  in_valid, in_part, in_last, out_ready,
    output in_ready, out_valid, out_frag, out_len, out_err
  );
endinterface

// File: rtl/extender_part_collector.sv
// Extender part collector: accepts one-hot encoded parts, decodes each base
// to BASE_LEN bits, packs them into a FRAG_LEN-base fragment and presents the
// fragment with a valid/ready handshake.
// Optional build macro ONE_HOT_CHECK_EN: when defined, non-one-hot codes decode
// to 0 and raise a sticky per-fragment error on out_err; when undefined, codes
// are OR-encoded without checking and out_err is tied low.
module extender_part_collector #(
  parameter int unsigned BASE_LEN       = 2,
  parameter int unsigned ONE_HOT_LEN    = 4,
  parameter int unsigned PART_COUNT     = 2,
  parameter int unsigned FRAG_LEN       = 256,
  parameter int unsigned PARTS_PER_FRAG = FRAG_LEN / PART_COUNT,
  parameter int unsigned LEN_W          = $clog2(FRAG_LEN + 1)
) (
  input logic                     clk,
  input logic                     rst,
  extender_part_collector_if.slave bus
);

  localparam int unsigned FRAG_W = BASE_LEN * FRAG_LEN;
  localparam int unsigned PART_W = BASE_LEN * PART_COUNT;
  localparam int unsigned IDX_W  = $clog2(FRAG_W);
  localparam int unsigned CNT_W  = $clog2(PARTS_PER_FRAG + 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [FRAG_W-1:0] frag;
  logic [FRAG_W-1:0] frag_d;
  logic [IDX_W-1:0]  part_idx;
  logic [PART_W-1:0] dec_part;
  logic              take;
  logic              closing;

  // Index of the highest set bit position, OR-combined: exact for one-hot codes
  function automatic logic [BASE_LEN-1:0] or_encode(input logic [ONE_HOT_LEN-1:0] code);
    logic [BASE_LEN-1:0] base;
    base = '0;
    for (int unsigned j = 0; j < ONE_HOT_LEN; j++) begin
      if (code[j]) base = base | BASE_LEN'(j);
    end
    return base;
  endfunction

`ifdef ONE_HOT_CHECK_EN
  function automatic logic is_one_hot(input logic [ONE_HOT_LEN-1:0] code);
    int unsigned ones;
    ones = 0;
    for (int unsigned j = 0; j < ONE_HOT_LEN; j++) begin
      ones = ones + 32'(code[j]);
    end
    return ones == 1;
  endfunction

  logic [PART_COUNT-1:0] dec_bad;
  logic                  any_bad;
  logic                  err;
`endif

  // Per-base decoders; base p of the part lands at the lower base index for lower p
  for (genvar p = 0; p < PART_COUNT; p++) begin : g_dec
    logic [ONE_HOT_LEN-1:0] code;
    assign code = bus.in_part[p*ONE_HOT_LEN +: ONE_HOT_LEN];
`ifdef ONE_HOT_CHECK_EN
    assign dec_bad[p] = !is_one_hot(code);
    assign dec_part[p*BASE_LEN +: BASE_LEN] = dec_bad[p] ? '0 : or_encode(code);
`else
    assign dec_part[p*BASE_LEN +: BASE_LEN] = or_encode(code);
`endif
  end

`ifdef ONE_HOT_CHECK_EN
  assign any_bad = |dec_bad;
`endif

  assign take     = bus.in_valid && bus.in_ready;
  assign part_idx = IDX_W'(32'(cnt) * PART_W);

  // State, part counter and fragment storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      frag  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      frag  <= frag_d;
    end
  end

  // Next-state: collect parts until in_last or a full fragment, then hold for the sink
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    frag_d  = frag;
    closing = 1'b0;
    unique case (state)
      COLLECT: begin
        if (take) begin
          frag_d[part_idx +: PART_W] = dec_part;
          cnt_d   = cnt + 1'b1;
          closing = bus.in_last || (cnt == CNT_W'(PARTS_PER_FRAG - 1));
          if (closing) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          frag_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

`ifdef ONE_HOT_CHECK_EN
  // Sticky invalid-code flag, cleared when the fragment is handed off
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == HOLD && bus.out_ready) begin
      err <= 1'b0;
    end else if (take && any_bad) begin
      err <= 1'b1;
    end
  end

  assign bus.out_err = err;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = (state == COLLECT) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_frag  = frag;
  assign bus.out_len   = LEN_W'(32'(cnt) * PART_COUNT);

endmodule

// File: tb/tb_extender_part_collector.sv
// Scoreboard bench for extender_part_collector: a driver feeds parts and a
// reference model turns each accepted part into expected fragments queued for
// a negedge monitor that compares every cycle the DUT presents a fragment.
module tb_extender_part_collector;

  localparam int unsigned BASE_LEN    = 2;
  localparam int unsigned ONE_HOT_LEN = 4;
  localparam int unsigned PART_COUNT  = 2;
  localparam int unsigned FRAG_LEN    = 256;
  localparam int unsigned LEN_W       = $clog2(FRAG_LEN + 1);
  localparam int unsigned FW          = BASE_LEN * FRAG_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  extender_part_collector_if #(
    .BASE_LEN   (BASE_LEN),
    .ONE_HOT_LEN(ONE_HOT_LEN),
    .PART_COUNT (PART_COUNT),
    .FRAG_LEN   (FRAG_LEN),
    .LEN_W      (LEN_W)
  ) bus ();

  extender_part_collector #(
    .BASE_LEN   (BASE_LEN),
    .ONE_HOT_LEN(ONE_HOT_LEN),
    .PART_COUNT (PART_COUNT),
    .FRAG_LEN   (FRAG_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [FW-1:0] frag;
    int unsigned   len;
    logic          err;
  } frag_t;

  frag_t      exp_q[$];
  logic [1:0] cur_bases[$];
  logic       cur_err = 1'b0;
  int         bp_mode = 2;  // 0 random out_ready, 1 held low, 2 held high

  task automatic check_vec(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference decode: returns {bad, base}
  function automatic logic [2:0] model_decode(input logic [3:0] code);
`ifdef ONE_HOT_CHECK_EN
    case (code)
      4'b0001: return 3'b0_00;
      4'b0010: return 3'b0_01;
      4'b0100: return 3'b0_10;
      4'b1000: return 3'b0_11;
      default: return 3'b1_00;
    endcase
`else
    return {1'b0, code[3] | code[2], code[3] | code[1]};
`endif
  endfunction

  task automatic model_close();
    frag_t f;
    f.frag = '0;
    foreach (cur_bases[i]) f.frag = f.frag | (FW'(cur_bases[i]) << (2 * i));
    f.len = cur_bases.size();
    f.err = cur_err;
    exp_q.push_back(f);
    cur_bases.delete();
    cur_err = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] part, input logic last);
    logic [2:0] d0;
    logic [2:0] d1;
    d0 = model_decode(part[3:0]);
    d1 = model_decode(part[7:4]);
    cur_bases.push_back(d0[1:0]);
    cur_bases.push_back(d1[1:0]);
    cur_err = cur_err | d0[2] | d1[2];
    if (last || cur_bases.size() == FRAG_LEN) model_close();
  endtask

  // Called at posedge+1; returns at posedge+1 after the part is taken
  task automatic send_part(input logic [7:0] part, input logic last);
    logic rdy;
    int unsigned budget;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_part  = part;
    bus.in_last  = last;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      budget++;
    end while (!rdy && budget < 1000);
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", budget);
    end else begin
      model_accept(part, last);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n > 0) #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d fragments outstanding, required 0", exp_q.size());
    end
  endtask

  function automatic logic [7:0] rand_part();
    logic [3:0] lo;
    logic [3:0] hi;
    if ($urandom_range(0, 9) == 0) return 8'($urandom());
    lo = 4'b0001 << $urandom_range(0, 3);
    hi = 4'b0001 << $urandom_range(0, 3);
    return {hi, lo};
  endfunction

  // Sink side: out_ready policy, updated just after each rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: fragment contents against the scoreboard every valid cycle
  initial begin
    logic prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) begin
        check_bit("in_ready_after_handshake", bus.in_ready, 1'b1);
        check_bit("out_valid_drop", bus.out_valid, 1'b0);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_fragment: out_valid=1 with len %0d, required no fragment", bus.out_len);
        end else begin
          check_vec("out_frag", bus.out_frag, exp_q[0].frag);
          check_vec("out_len", FW'(bus.out_len), FW'(exp_q[0].len));
          check_bit("out_err", bus.out_err, exp_q[0].err);
          check_bit("in_ready_in_hold", bus.in_ready, 1'b0);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int unsigned n;
    bus.in_valid = 1'b0;
    bus.in_part  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_out_err", bus.out_err, 1'b0);
    check_vec("rst_out_len", FW'(bus.out_len), '0);
    check_vec("rst_out_frag", bus.out_frag, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_bit("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Full fragment closed by in_last on part 128
    for (int unsigned i = 0; i < 128; i++) send_part(8'h21, i == 127);
    @(negedge clk);
    check_bit("full_latency", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Short fragment
    send_part(8'h81, 1'b0);
    send_part(8'h14, 1'b0);
    send_part(8'h42, 1'b1);
    @(negedge clk);
    check_bit("short_latency", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure with in_valid asserted during HOLD
    bp_mode = 1;
    send_part(8'h18, 1'b0);
    send_part(8'h24, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_part  = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bp_mode = 2;
    wait_drain();

    // Invalid code inside a 4-part fragment, then a clean one
    send_part(8'h12, 1'b0);
    send_part(8'h30, 1'b0);
    send_part(8'h84, 1'b0);
    send_part(8'h21, 1'b1);
    send_part(8'h48, 1'b0);
    send_part(8'h12, 1'b1);
    wait_drain();

    // Auto-close at 128 parts, remaining two parts form the next fragment
    for (int unsigned i = 0; i < 130; i++) send_part(rand_part(), i == 129);
    wait_drain();

    // Reset mid-fragment discards collected data
    for (int unsigned i = 0; i < 50; i++) send_part(rand_part(), 1'b0);
    rst = 1'b1;
    cur_bases.delete();
    cur_err = 1'b0;
    @(negedge clk);
    check_bit("midrst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_vec("midrst_out_frag", bus.out_frag, '0);
    @(posedge clk);
    #1;
    send_part(8'h84, 1'b0);
    send_part(8'h21, 1'b1);
    wait_drain();

    // Randomized fragments with random backpressure and input gaps
    bp_mode = 0;
    for (int unsigned f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0:       n = 128;
        1:       n = $urandom_range(100, 160);
        default: n = $urandom_range(1, 12);
      endcase
      for (int unsigned i = 0; i < n; i++) begin
        send_part(rand_part(), i == n - 1);
        if ($urandom_range(0, 4) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    bp_mode = 2;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
